// File: rtl/bob_retire_rd_pkg.sv
// bob_retire_rd_pkg: shared bob geometry (entry width, index width, entry count).
package bob_retire_rd_pkg;
    localparam int BOB_WIDTH      = 32;
    localparam int BOB_ADDR_WIDTH = 6;
    localparam int BOB_COUNT      = 48;
endpackage

// File: rtl/bob_rd_skid.sv
// bob_rd_skid: 2-entry FIFO holding retired bob entries; head is the oldest slot.
module bob_rd_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   cnt,
    output logic [W-1:0] head
);
    logic [W-1:0] s1;
    logic [1:0]   wr_idx;
    // A pop shifts slot 1 forward first, so the push lands behind whatever survives.
    assign wr_idx = cnt - {1'b0, pop};
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            s1   <= '0;
        end else begin
            if (pop) head <= s1;
            if (push && wr_idx == 2'd0) head <= din;
            if (push && wr_idx == 2'd1) s1 <= din;
            cnt <= flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/bob_retire_rd.sv
// bob_retire_rd: reads the bob head from RAM, pops one entry per cycle into a skid FIFO.
// Define BOB_RETIRE_RD_STATS_EN to add retire_count/stall_count outputs.
module bob_retire_rd
    import bob_retire_rd_pkg::*;
#(
    parameter int DATA_WIDTH = BOB_WIDTH,
    parameter int ADDR_WIDTH = BOB_ADDR_WIDTH,
    parameter int DEPTH      = BOB_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  except,
    input  logic                  hasRetire,
    input  logic [ADDR_WIDTH-1:0] retire_addr,
    output logic                  doRetire,
    output logic                  read_clkEn,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef BOB_RETIRE_RD_STATS_EN
    ,
    output logic [31:0]           retire_count,
    output logic [31:0]           stall_count
`endif
);
    logic [1:0] cnt;
    logic       pop;
    // The RAM address register tracks the allocator's next head, so read_data is always the head.
    assign read_clkEn = 1'b1;
    assign read_addr  = retire_addr;
    assign out_valid  = cnt != 2'd0;
    assign pop        = out_valid & out_ready;
    assign doRetire   = hasRetire & ~except & ~rst & (cnt < 2'd2 | (cnt == 2'd2 & pop));
    bob_rd_skid #(.W(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (doRetire),
        .pop   (pop),
        .flush (except),
        .din   (read_data),
        .cnt   (cnt),
        .head  (out_data)
    );
    always_ff @(posedge clk) begin
        if (!rst && hasRetire) assert (32'(retire_addr) < DEPTH);
    end
`ifdef BOB_RETIRE_RD_STATS_EN
    // A flush cycle is not counted as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            if (doRetire) retire_count <= retire_count + 32'd1;
            if (hasRetire & ~except & cnt == 2'd2 & ~pop) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
